// File: rtl/mul_shiftadd.sv
// Iterative shift-add multiplier: full 2*DATA_W-bit signed/unsigned product, one multiplier bit
// per cycle. Optional MUL_SHIFTADD_EARLY_EXIT_EN skips iterations once the remaining bits are zero.
module mul_shiftadd #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sign,
    output logic                  done,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned PcW = $clog2(DATA_W + 3) + 1;
    localparam logic [PcW-1:0] PcLastIter = PcW'(DATA_W);
    localparam logic [PcW-1:0] PcSign     = PcW'(DATA_W + 1);
    localparam logic [PcW-1:0] PcHold     = PcW'(DATA_W + 2);

    logic [2*DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic                neg_q, neg_d;
    logic [PcW-1:0]      pc_q, pc_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   a_mag, b_mag, lo, hi;
    logic [DATA_W:0]     sum;

    // Magnitudes as unsigned; the most negative value maps onto 2^(DATA_W-1) without overflow.
    assign a_mag = (sign && multiplicand[DATA_W-1]) ? -multiplicand : multiplicand;
    assign b_mag = (sign && multiplier[DATA_W-1])   ? -multiplier   : multiplier;
    assign lo    = p_q[DATA_W-1:0];
    assign hi    = p_q[2*DATA_W-1:DATA_W];
    assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand_q} : '0);

`ifdef MUL_SHIFTADD_EARLY_EXIT_EN
    logic [DATA_W-1:0] rem_bits;
    // Unprocessed multiplier bits are the low DATA_W+1-pc bits of lo.
    assign rem_bits = lo << (pc_q - 1'b1);
`endif

    always_comb begin
        p_d     = p_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        pc_d    = pc_q;
        done_d  = done_q;
        if (!en) begin
            p_d    = '0;
            pc_d   = '0;
            done_d = 1'b0;
        end else if (pc_q == '0) begin
            mcand_d = a_mag;
            neg_d   = sign & (multiplicand[DATA_W-1] ^ multiplier[DATA_W-1]);
            p_d     = {{DATA_W{1'b0}}, b_mag};
            pc_d    = pc_q + 1'b1;
            done_d  = 1'b0;
        end else if (pc_q <= PcLastIter) begin
`ifdef MUL_SHIFTADD_EARLY_EXIT_EN
            if (rem_bits == '0) begin
                p_d  = p_q >> (PcSign - pc_q);
                pc_d = PcSign;
            end else begin
                p_d  = {sum, lo[DATA_W-1:1]};
                pc_d = pc_q + 1'b1;
            end
`else
            p_d  = {sum, lo[DATA_W-1:1]};
            pc_d = pc_q + 1'b1;
`endif
        end else if (pc_q == PcSign) begin
            p_d    = neg_q ? -p_q : p_q;
            done_d = 1'b1;
            pc_d   = PcHold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign product = p_q;

endmodule

// File: tb/tb_mul_shiftadd.sv
// Self-checking bench for mul_shiftadd (DATA_W=32) against an arithmetic product/latency model.
// Follows MUL_SHIFTADD_EARLY_EXIT_EN for the expected latency.
module tb_mul_shiftadd;

    logic        clk = 1'b0;
    logic        rst, en, sign, done;
    logic [31:0] multiplicand, multiplier;
    logic [63:0] product;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ecount   = 0;
    bit          armed    = 1'b0;
    logic [63:0] exp_prod = '0;
    int          exp_lat  = 34;

`ifdef MUL_SHIFTADD_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    mul_shiftadd #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sign         (sign),
        .done         (done),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int          k;
        m = (s && b[31]) ? -b : b;
        k = -1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return (EarlyExit && (k + 4 < 34)) ? k + 4 : 34;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges seen with en high since the last clear.
    always @(posedge clk) ecount <= (rst || !en) ? 0 : ecount + 1;

    always @(negedge clk) begin
        if (armed) begin
            if (ecount == 0) begin
                chk("clear_done", 64'(done), 64'(0));
                chk("clear_product", product, 64'(0));
            end else begin
                chk("done_timing", 64'(done), 64'(ecount >= exp_lat));
                if (ecount >= exp_lat) chk("model_product", product, exp_prod);
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        multiplicand = a;
        multiplier   = b;
        sign         = s;
        exp_prod     = model_prod(a, b, s);
        exp_lat      = model_lat(b, s);
        en           = 1'b1;
    endtask

    task automatic wait_done(input string name, input logic [63:0] lit, input bit scramble);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (scramble) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
                sign         = 1'($urandom_range(0, 1));
            end
            if (done) break;
        end
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_product"}, product, lit);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_held"}, product, lit);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] lit, input bit scramble);
        start_op(a, b, s);
        wait_done(name, lit, scramble);
    endtask

    task automatic run_abort(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [63:0] lit, input bit use_rst);
        start_op(a, b, s);
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         en  = 1'b0;
        @(posedge clk); #1;
        chk({name, "_abort_done"}, 64'(done), 64'(0));
        chk({name, "_abort_product"}, product, 64'(0));
        rst = 1'b0;
        en  = 1'b1;
        wait_done(name, lit, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        sign         = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_product", product, 64'(0));
        rst = 1'b0;

        run_op("u_3x5",       32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F, 1'b0);
        run_op("s_m7x6",      32'hFFFF_FFF9,  32'd6,          1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run_op("u_m7x6",      32'hFFFF_FFF9,  32'd6,          1'b0, 64'h0000_0005_FFFF_FFD6, 1'b0);
        run_op("s_min_x_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_8000_0000, 1'b0);
        run_op("u_max_sq",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("s_min_sq",    32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 1'b0);
        run_op("s_m1_sq",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001, 1'b0);
        run_op("u_b0",        32'd12345,      32'd0,          1'b0, 64'h0,                   1'b0);
        run_op("u_9x1",       32'd9,          32'd1,          1'b0, 64'h0000_0000_0000_0009, 1'b0);
        run_op("u_3xmsb",     32'd3,          32'h8000_0000,  1'b0, 64'h0000_0001_8000_0000, 1'b0);
        run_op("s_scramble",  32'd12345,      32'hFFFF_FF9C,  1'b1, 64'hFFFF_FFFF_FFED_29BC, 1'b1);
        run_abort("rst_pc10", 32'd1000,       32'd1000,       1'b0, 64'h0000_0000_000F_4240, 1'b1);
        run_abort("en_pc10",  32'hFFFF_FFFF,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);

        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
